oscillator_neuron_array: RTL

Bank of NUM_NEURONS digital phase oscillators forming the neuron side of the ONN coupling loop. Each neuron emits a 50%-duty square wave (osc_out), which feeds the synapse block's per-neuron inputs. Each neuron also consumes the synapse block's per-neuron square-wave output (syn_in) and nudges its own phase by one step per observed edge toward it. Phase vectors are loaded through a valid/ready port. Settling is reported, and phases can be read back.

---
 rtl/oscillator_neuron_array.sv | 129 ++++++++++++
 1 files changed

// File: rtl/oscillator_neuron_array.sv
// rtl/oscillator_neuron_array.sv - bank of digital phase oscillators with edge-driven phase correction
module oscillator_neuron_array #(
    parameter int NUM_NEURONS  = 15,
    parameter int PHASE_BITS   = 4,
    parameter int IDX_BITS     = 4,
    parameter int LOCK_PERIODS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [IDX_BITS-1:0]    load_idx,
    input  logic [PHASE_BITS-1:0]  load_phase,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NUM_NEURONS-1:0] syn_in,
    output logic [NUM_NEURONS-1:0] osc_out,
    output logic                   busy,
    output logic                   settled,
    input  logic [IDX_BITS-1:0]    rd_idx,
    output logic [PHASE_BITS-1:0]  rd_phase
);
    localparam int QW = $clog2(LOCK_PERIODS + 1);
    localparam logic [PHASE_BITS-1:0] HALF  = PHASE_BITS'(1) << (PHASE_BITS - 1);
    localparam logic [PHASE_BITS-1:0] LAST  = '1;
    localparam logic [QW-1:0]         LOCK  = QW'(LOCK_PERIODS);
    localparam logic [IDX_BITS:0]     N_LIM = (IDX_BITS + 1)'(NUM_NEURONS);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 state, state_nx;
    logic [PHASE_BITS-1:0]  ph      [NUM_NEURONS];
    logic [PHASE_BITS-1:0]  ph_nx   [NUM_NEURONS];
    logic [PHASE_BITS-1:0]  init_ph [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] prev_syn, syn_rise, corr_v;
    logic [PHASE_BITS-1:0]  gp;
    logic [QW-1:0]          quiet_cnt;
    logic                   win_corr, win_any, any_corr, run_step, load_fire;

    always_comb begin
        state_nx   = state;
        load_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (stop) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign run_step  = busy & ~stop;
    assign load_fire = load_valid & load_ready;
    assign settled   = busy & (quiet_cnt == LOCK);

    // Ahead (1..HALF) waits one cycle, behind (HALF+1..P-1) skips one step.
    always_comb begin
        syn_rise = '0;
        corr_v   = '0;
        osc_out  = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            syn_rise[i] = syn_in[i] & ~prev_syn[i];
            corr_v[i]   = syn_rise[i] & (ph[i] != '0);
            if (!corr_v[i])
                ph_nx[i] = ph[i] + PHASE_BITS'(1);
            else if (ph[i] <= HALF)
                ph_nx[i] = ph[i];
            else
                ph_nx[i] = ph[i] + PHASE_BITS'(2);
            osc_out[i] = busy & ~ph[i][PHASE_BITS-1];
        end
    end

    assign any_corr = run_step & (|corr_v);
    assign win_any  = win_corr | any_corr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prev_syn  <= '0;
            gp        <= '0;
            quiet_cnt <= '0;
            win_corr  <= 1'b0;
            rd_phase  <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                ph[i]      <= '0;
                init_ph[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            prev_syn <= syn_in;
            rd_phase <= ({1'b0, rd_idx} < N_LIM) ? ph[rd_idx] : '0;
            if (state == S_IDLE) begin
                for (int i = 0; i < NUM_NEURONS; i++)
                    if (load_fire && load_idx == IDX_BITS'(i)) init_ph[i] <= load_phase;
                if (start) begin
                    // Same-cycle load bypasses the init register.
                    for (int i = 0; i < NUM_NEURONS; i++)
                        ph[i] <= (load_fire && load_idx == IDX_BITS'(i)) ? load_phase : init_ph[i];
                    gp        <= '0;
                    quiet_cnt <= '0;
                    win_corr  <= 1'b0;
                end
            end else if (stop) begin
                quiet_cnt <= '0;
                win_corr  <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_NEURONS; i++)
                    ph[i] <= ph_nx[i];
                gp <= gp + PHASE_BITS'(1);
                if (gp == LAST) begin
                    win_corr <= 1'b0;
                    if (win_any)
                        quiet_cnt <= '0;
                    else if (quiet_cnt != LOCK)
                        quiet_cnt <= quiet_cnt + QW'(1);
                end else begin
                    win_corr <= win_any;
                    if (any_corr) quiet_cnt <= '0;
                end
            end
        end
    end
endmodule
